// File: rtl/gate_vec_collector.sv
// Gate-stream sink: packs TILE_SIZE-wide beats into D-element frames held in a ping-pong buffer.
// Latency: a frame is readable the cycle after its last beat; tile reads return 1 cycle after rd_en.
// Backpressure: in_ready drops only while both buffers hold unreleased frames. Option: GATE_VEC_COLLECTOR_ERR_EN.
module gate_vec_collector #(
    parameter int  TILE_SIZE  = 4,
    parameter int  DATA_WIDTH = 16,
    parameter int  D          = 256,
    localparam int NTILE      = D / TILE_SIZE,
    localparam int TADDR_W    = (NTILE > 1) ? $clog2(NTILE) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] in_vec,
    output logic                                 frame_valid,
    input  logic                                 rd_en,
    input  logic [TADDR_W-1:0]                   rd_addr,
    output logic                                 rd_valid,
    output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] rd_vec,
    input  logic                                 frame_release,
    output logic [15:0]                          frame_cnt,
    output logic [TADDR_W-1:0]                   wr_tile_idx
`ifdef GATE_VEC_COLLECTOR_ERR_EN
    ,
    output logic                                 err_sticky
`endif
);

    typedef logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] tile_t;

    localparam logic [TADDR_W-1:0] LAST_TILE = TADDR_W'(NTILE - 1);

    tile_t              mem [2][NTILE];
    logic               wr_buf;
    logic               rd_buf;
    logic [TADDR_W-1:0] wr_tile;
    logic [1:0]         buf_full;
    logic [1:0]         buf_full_nxt;

    logic wr_fire;
    logic wr_last;
    logic rd_fire;
    logic rel_fire;

    // A buffer is only written while not full, so a release never races a write into the same buffer.
    assign in_ready    = !rst && !buf_full[wr_buf];
    assign frame_valid = buf_full[rd_buf];
    assign wr_fire     = in_valid && in_ready;
    assign wr_last     = wr_fire && (wr_tile == LAST_TILE);
    assign rd_fire     = rd_en && frame_valid;
    assign rel_fire    = frame_release && frame_valid;
    assign wr_tile_idx = wr_tile;

    always_comb begin
        buf_full_nxt = buf_full;
        if (rel_fire) buf_full_nxt[rd_buf] = 1'b0;
        if (wr_last)  buf_full_nxt[wr_buf] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_buf    <= 1'b0;
            rd_buf    <= 1'b0;
            wr_tile   <= '0;
            buf_full  <= 2'b00;
            frame_cnt <= 16'd0;
            rd_valid  <= 1'b0;
            rd_vec    <= '0;
        end else begin
            buf_full <= buf_full_nxt;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_tile   <= '0;
                    wr_buf    <= ~wr_buf;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    wr_tile <= wr_tile + TADDR_W'(1);
                end
            end
            if (rel_fire) rd_buf <= ~rd_buf;
            // Read samples the pre-release rd_buf, so a same-cycle release still returns its frame.
            rd_valid <= rd_fire;
            if (rd_fire) rd_vec <= mem[rd_buf][rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_buf][wr_tile] <= in_vec;
    end

`ifdef GATE_VEC_COLLECTOR_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if ((rd_en && !frame_valid) || (frame_release && !frame_valid) ||
                     (rd_en && (int'(rd_addr) >= NTILE))) begin
            err_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gate_vec_collector.sv
// Bench for gate_vec_collector: directed read table, hand-written corner sequences, random traffic vs a frame-queue model.
module tb_gate_vec_collector;
    localparam int TS = 4;
    localparam int DW = 16;
    localparam int D  = 256;
    localparam int NT = D / TS;
    localparam int AW = $clog2(NT);

    typedef logic [TS*DW-1:0] tile_t;
    typedef struct {
        int addr;
        int elem;
    } rd_rec_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [TS-1:0][DW-1:0]  in_vec = '0;
    logic                   frame_valid;
    logic                   rd_en = 1'b0;
    logic [AW-1:0]          rd_addr = '0;
    logic                   rd_valid;
    logic [TS-1:0][DW-1:0]  rd_vec;
    logic                   frame_release = 1'b0;
    logic [15:0]            frame_cnt;
    logic [AW-1:0]          wr_tile_idx;
`ifdef GATE_VEC_COLLECTOR_ERR_EN
    logic                   err_sticky;
`endif

    int total = 0;
    int bad   = 0;

    // Model: completed frames as a flat FIFO of tiles (oldest frame first), plus the frame being assembled.
    tile_t       full_q[$];
    tile_t       part_q[$];
    tile_t       m_rd_vec   = '0;
    logic        m_rd_valid = 1'b0;
    logic [15:0] m_cnt      = 16'd0;

    rd_rec_t tbl[5];

    always #5 clk = ~clk;

    gate_vec_collector #(.TILE_SIZE(TS), .DATA_WIDTH(DW), .D(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_vec        (in_vec),
        .frame_valid   (frame_valid),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_vec        (rd_vec),
        .frame_release (frame_release),
        .frame_cnt     (frame_cnt),
        .wr_tile_idx   (wr_tile_idx)
`ifdef GATE_VEC_COLLECTOR_ERR_EN
        ,
        .err_sticky    (err_sticky)
`endif
    );

    function automatic int nfull();
        return full_q.size() / NT;
    endfunction

    function automatic tile_t splat(int v);
        tile_t t;
        for (int i = 0; i < TS; i++) t[i*DW +: DW] = DW'(v);
        return t;
    endfunction

    function automatic tile_t lanes(int v);
        tile_t t;
        for (int i = 0; i < TS; i++) t[i*DW +: DW] = DW'(v * TS + i);
        return t;
    endfunction

    task automatic chk(input string nm, input tile_t act, input tile_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // One clock: inputs are already driven; model advances with the edge, outputs checked 1 time unit later.
    task automatic cycle();
        bit    wr, rd, rl;
        tile_t v, junk;
        int    a;
        wr = in_valid && (nfull() < 2);
        rd = rd_en && (nfull() > 0);
        rl = frame_release && (nfull() > 0);
        v  = in_vec;
        a  = int'(rd_addr);
        @(posedge clk);
        m_rd_valid = rd;
        if (rd) m_rd_vec = full_q[a];
        if (rl) for (int i = 0; i < NT; i++) junk = full_q.pop_front();
        if (wr) begin
            part_q.push_back(v);
            if (part_q.size() == NT) begin
                for (int i = 0; i < NT; i++) full_q.push_back(part_q[i]);
                part_q.delete();
                m_cnt++;
            end
        end
        #1;
        chk("in_ready",    64'(in_ready),    64'(nfull() < 2));
        chk("frame_valid", 64'(frame_valid), 64'(nfull() > 0));
        chk("rd_valid",    64'(rd_valid),    64'(m_rd_valid));
        chk("rd_vec",      64'(rd_vec),      m_rd_vec);
        chk("frame_cnt",   64'(frame_cnt),   64'(m_cnt));
        chk("wr_tile_idx", 64'(wr_tile_idx), 64'(part_q.size()));
    endtask

    task automatic push_beat(input tile_t v);
        bit acc;
        in_valid = 1'b1;
        in_vec   = v;
        for (int k = 0; k < 200; k++) begin
            acc = (nfull() < 2);
            cycle();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        fail_now("push_timeout");
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        in_valid      = 1'b0;
        rd_en         = 1'b0;
        frame_release = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        full_q.delete();
        part_q.delete();
        m_cnt      = 16'd0;
        m_rd_valid = 1'b0;
        m_rd_vec   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_wr_tile_idx", 64'(wr_tile_idx), 64'(0));
        chk("rst_frame_cnt",   64'(frame_cnt),   64'(0));
        chk("rst_frame_valid", 64'(frame_valid), 64'(0));
        chk("rst_rd_valid",    64'(rd_valid),    64'(0));
        chk("rst_rd_vec",      64'(rd_vec),      64'(0));
`ifdef GATE_VEC_COLLECTOR_ERR_EN
        chk("rst_err_sticky",  64'(err_sticky),  64'(0));
`endif
    endtask

    initial begin
        int    beats, raddr, dly, cyc, mask;
        bit    acc;

        tbl[0] = '{addr: 10, elem: 10};
        tbl[1] = '{addr: 0,  elem: 0};
        tbl[2] = '{addr: 63, elem: 63};
        tbl[3] = '{addr: 31, elem: 31};
        tbl[4] = '{addr: 10, elem: 10};

        @(posedge clk);
        #1;
        do_reset();

        // Frame 0: beat value = beat index.
        for (int b = 0; b < NT; b++) push_beat(splat(b));
        chk("f0_frame_cnt", 64'(frame_cnt), 64'(1));
        for (int i = 0; i < 5; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(tbl[i].addr);
            cycle();
            rd_en = 1'b0;
            chk("tbl_rd_valid", 64'(rd_valid), 64'(1));
            chk("tbl_rd_vec",   64'(rd_vec),   splat(tbl[i].elem));
            cycle();
        end

        // Frame 1, then beat 128 must stall with both buffers full.
        for (int b = NT; b < 2 * NT; b++) push_beat(splat(b));
        in_valid = 1'b1;
        in_vec   = splat(2 * NT);
        repeat (3) cycle();
        chk("full_in_ready",  64'(in_ready),  64'(0));
        chk("full_frame_cnt", 64'(frame_cnt), 64'(2));

        // Read and release frame 0 in the same cycle.
        rd_en         = 1'b1;
        rd_addr       = AW'(5);
        frame_release = 1'b1;
        cycle();
        rd_en         = 1'b0;
        frame_release = 1'b0;
        chk("rdrel_rd_vec",      64'(rd_vec),      splat(5));
        chk("rdrel_rd_valid",    64'(rd_valid),    64'(1));
        chk("rdrel_frame_valid", 64'(frame_valid), 64'(1));
        chk("rdrel_in_ready",    64'(in_ready),    64'(1));
        push_beat(splat(2 * NT));
        chk("after_wr_tile_idx", 64'(wr_tile_idx), 64'(1));

        rd_en   = 1'b1;
        rd_addr = AW'(0);
        cycle();
        chk("f1_rd0", 64'(rd_vec), splat(NT));
        rd_addr = AW'(NT - 1);
        cycle();
        rd_en = 1'b0;
        chk("f1_rd63", 64'(rd_vec), splat(2 * NT - 1));
        frame_release = 1'b1;
        cycle();
        frame_release = 1'b0;
        chk("f1_released", 64'(frame_valid), 64'(0));

        // Read and release with no frame present: both ignored.
        rd_en         = 1'b1;
        rd_addr       = AW'(3);
        frame_release = 1'b1;
        cycle();
        rd_en         = 1'b0;
        frame_release = 1'b0;
        chk("empty_rd_valid", 64'(rd_valid), 64'(0));
`ifdef GATE_VEC_COLLECTOR_ERR_EN
        chk("empty_err_sticky", 64'(err_sticky), 64'(1));
`endif
        cycle();

        // Reset with a partial frame of 30 beats in flight.
        for (int b = 2 * NT + 1; b < 2 * NT + 30; b++) push_beat(splat(b));
        chk("partial_idx", 64'(wr_tile_idx), 64'(30));
        in_valid = 1'b1;
        do_reset();
        for (int b = 0; b < NT; b++) push_beat(splat(1000 + b));
        chk("fresh_frame_cnt", 64'(frame_cnt), 64'(1));
        rd_en   = 1'b1;
        rd_addr = AW'(7);
        cycle();
        rd_en = 1'b0;
        chk("fresh_rd7", 64'(rd_vec), splat(1007));
        frame_release = 1'b1;
        cycle();
        frame_release = 1'b0;

        // Random producer and consumer; each frame is read in an XOR-permuted order.
        beats = 0;
        raddr = 0;
        dly   = 0;
        cyc   = 0;
        mask  = $urandom_range(0, NT - 1);
        while ((beats < 1000 || nfull() > 0) && cyc < 30000) begin
            in_valid      = (beats < 1000) && ($urandom_range(0, 1) == 1);
            in_vec        = lanes(5000 + beats);
            rd_en         = 1'b0;
            frame_release = 1'b0;
            if (nfull() > 0) begin
                if (raddr < NT) begin
                    if ($urandom_range(0, 3) != 0) begin
                        rd_en   = 1'b1;
                        rd_addr = AW'(raddr ^ mask);
                        raddr++;
                    end
                end else if (dly == 0) begin
                    frame_release = 1'b1;
                    raddr = 0;
                    mask  = $urandom_range(0, NT - 1);
                    dly   = $urandom_range(0, 6);
                end else begin
                    dly--;
                end
            end
            acc = in_valid && (nfull() < 2);
            cycle();
            if (acc) beats++;
            cyc++;
        end
        in_valid      = 1'b0;
        rd_en         = 1'b0;
        frame_release = 1'b0;
        if (cyc >= 30000) fail_now("random_drain_timeout");
        chk("random_frame_cnt", 64'(frame_cnt), 64'(16'((1000 / NT) + 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_vec_collector.md
Name: gate_vec_collector

Overview:
- Stream sink at the end of the sigmoid stage.
- Accepts the TILE_SIZE-wide Q0.16 gate stream over valid/ready and assembles D-element frames into a ping-pong (2-frame) buffer.
- Exposes completed frames to the downstream elementwise/scan stage through a random-access tile read port with an explicit release handshake.
- Backpressures the sigmoid stage only when both frame buffers are occupied.

Parameters:
- TILE_SIZE, 4, elements per stream beat and per read word
- DATA_WIDTH, 16, element width (Q0.16 unsigned)
- D, 256, elements per frame; must be a multiple of TILE_SIZE
- NTILE, D/TILE_SIZE, tiles per frame (localparam)
- TADDR_W, $clog2(NTILE), tile address width (localparam)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat ready
- in_vec  in  [DATA_WIDTH-1:0] x TILE_SIZE  input tile
- frame_valid  out  1  read-side buffer holds a complete frame
- rd_en  in  1  tile read request
- rd_addr  in  TADDR_W  tile index within the current read frame
- rd_valid  out  1  rd_vec valid (1-cycle pulse)
- rd_vec  out  [DATA_WIDTH-1:0] x TILE_SIZE  read tile data
- frame_release  in  1  pulse: consumer is done with the current read frame
- frame_cnt  out  16  completed-frame counter, wraps at 2^16
- wr_tile_idx  out  TADDR_W  debug: next tile slot to be written

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- State: wr_buf (1b), rd_buf (1b), wr_tile (TADDR_W), buf_full[1:0], memory mem[2][NTILE] of TILE_SIZE x DATA_WIDTH.
- Reset values: wr_buf=rd_buf=0, wr_tile=0, buf_full=00, rd_valid=0, rd_vec=0, frame_cnt=0. in_ready=0 while rst is high. Memory contents are not reset.
- Reset mid-operation: any partially filled frame and any full frames are discarded; a read pending in the reset cycle produces no rd_valid.
- Per-buffer FSM: EMPTY/FILLING -> FULL on write of tile NTILE-1; FULL -> EMPTY on accepted release.
- in_ready = !buf_full[wr_buf], combinational, never dependent on in_valid.
- Write on in_valid && in_ready:
  - mem[wr_buf][wr_tile] <= in_vec.
  - If wr_tile == NTILE-1: wr_tile <= 0, buf_full[wr_buf] <= 1, wr_buf toggles, frame_cnt increments.
  - Otherwise wr_tile increments.
- frame_valid = buf_full[rd_buf], combinational.
- Read on rd_en && frame_valid:
  - Next cycle: rd_vec = mem[rd_buf][rd_addr], rd_valid = 1. Fixed latency 1.
  - rd_vec holds its last value when rd_valid = 0.
  - rd_en while !frame_valid is ignored: no rd_valid, no state change.
  - Reads are non-destructive; any order and any repeats are allowed.
- Release on frame_release && frame_valid: buf_full[rd_buf] <= 0, rd_buf toggles. frame_release while !frame_valid is ignored.
- Simultaneous events:
  - rd_en + frame_release in the same cycle: the read returns data from the frame being released; rd_valid is asserted next cycle.
  - Final-tile write into wr_buf + release of rd_buf in the same cycle (wr_buf != rd_buf): both take effect, and frame_valid stays 1 next cycle.
  - Release of a buffer + write into that same buffer in the same cycle cannot occur, because in_ready is 0 for a full buffer. The freed buffer becomes writable the next cycle (1-cycle bubble).
- Full condition: both buffers full -> in_ready = 0 until a release. No beat is lost or overwritten.

Optional Feature:
- Macro: GATE_VEC_COLLECTOR_ERR_EN.
- Defined: adds output err_sticky (1b, reset 0). It sets and holds until reset on any of:
  - rd_en while !frame_valid
  - frame_release while !frame_valid
  - rd_en with rd_addr >= NTILE (only reachable when NTILE is not a power of two)
- Not defined: the port is absent; these events are silently ignored as described above.

Test Plan:
- Reset, then stream 64 beats with element value = beat index, D=256, TILE_SIZE=4, in_valid held high. Expect in_ready=1 throughout, frame_valid rising the cycle after beat 63, frame_cnt=1; reading rd_addr=10 returns {10,10,10,10} with rd_valid one cycle later.
- Stream 128 beats with no release. Expect frame_cnt=2 and in_ready=0 after beat 127; beat 128 is held with no overwrite. Release, then in_ready=1 the next cycle; reads of the frame-1 contents are correct.
- Issue rd_en and frame_release in the same cycle on frame 0. Expect rd_vec from frame 0 next cycle with rd_valid=1, and frame_valid following the frame-1 state.
- Issue rd_en and frame_release with frame_valid=0. Expect no rd_valid and no pointer change; err_sticky=1 only when GATE_VEC_COLLECTOR_ERR_EN is defined.
- Assert rst after 30 beats of a frame. Expect in_ready=0 during reset, wr_tile_idx=0 and frame_cnt=0 after; a fresh 64-beat frame completes normally.
- Toggle in_valid randomly for 1000 beats while a consumer reads all tiles and releases with random delay. Expect each frame to match a scoreboard and no beat to be lost or duplicated.
